// File: rtl/key_search_ctrl_if.sv
// Handshake and memory-read bundle between the key search controller
// and the RC4 core / D memory it supervises.
interface key_search_ctrl_if;
   logic        go_i;
   logic [23:0] key_o;
   logic        core_start_o;
   logic        start_loop_o;
   logic        pass_done_i;
   logic [7:0]  address_d_o;
   logic [7:0]  q_d_i;
   logic        busy_o;
   logic        found_o;
   logic        fail_o;

   // Controller side
   modport master (
      input  go_i,
      input  pass_done_i,
      input  q_d_i,
      output key_o,
      output core_start_o,
      output start_loop_o,
      output address_d_o,
      output busy_o,
      output found_o,
      output fail_o
   );

   // Core / memory / requester side
   modport slave (
      output go_i,
      output pass_done_i,
      output q_d_i,
      input  key_o,
      input  core_start_o,
      input  start_loop_o,
      input  address_d_o,
      input  busy_o,
      input  found_o,
      input  fail_o
   );
endinterface

// File: rtl/key_search_ctrl.sv
// Brute-force key search controller: steps the RC4 core through the key
// range, reads each decrypted message back and stops on the first key whose
// output is entirely lowercase letters and spaces.
module key_search_ctrl #(
   parameter int unsigned MSG_LEN   = 32,
   parameter logic [23:0] KEY_START = 24'h000000,
   parameter logic [23:0] KEY_END   = 24'h3FFFFF
) (
   input  logic             clk,
   input  logic             rst_n,
   key_search_ctrl_if.master bus
);

   localparam int unsigned KEY_W = 24;
   localparam int unsigned IDX_W = 8;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_START,
      S_WAIT_PASS,
      S_RD_ADDR,
      S_RD_WAIT,
      S_CHECK,
      S_NEXT_KEY,
      S_FOUND,
      S_FAIL
   } state_t;

   state_t             state_q, state_d;
   logic [KEY_W-1:0]   key_q, key_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               first_q, first_d;
   logic               busy_q, busy_d;
   logic               found_q, found_d;
   logic               fail_q, fail_d;
   logic               core_start_q, core_start_d;
   logic               start_loop_q, start_loop_d;

   // Plaintext acceptance: lowercase a..z or space
   function automatic logic byte_ok(input logic [7:0] b);
      return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
   endfunction

   // State register and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         key_q        <= KEY_START;
         idx_q        <= '0;
         first_q      <= 1'b0;
         busy_q       <= 1'b0;
         found_q      <= 1'b0;
         fail_q       <= 1'b0;
         core_start_q <= 1'b0;
         start_loop_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         key_q        <= key_d;
         idx_q        <= idx_d;
         first_q      <= first_d;
         busy_q       <= busy_d;
         found_q      <= found_d;
         fail_q       <= fail_d;
         core_start_q <= core_start_d;
         start_loop_q <= start_loop_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d      = state_q;
      key_d        = key_q;
      idx_d        = idx_q;
      first_d      = first_q;
      busy_d       = busy_q;
      found_d      = found_q;
      fail_d       = fail_q;
      core_start_d = 1'b0;
      start_loop_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.go_i) begin
               state_d = S_START;
               key_d   = KEY_START;
               first_d = 1'b1;
               busy_d  = 1'b1;
               found_d = 1'b0;
               fail_d  = 1'b0;
            end
         end
         S_START: begin
            core_start_d = first_q;
            start_loop_d = !first_q;
            state_d      = S_WAIT_PASS;
         end
         S_WAIT_PASS: begin
            if (bus.pass_done_i) begin
               idx_d   = '0;
               state_d = S_RD_ADDR;
            end
         end
         S_RD_ADDR: state_d = S_RD_WAIT;
         S_RD_WAIT: state_d = S_CHECK;
         S_CHECK: begin
            if (!byte_ok(bus.q_d_i)) begin
               state_d = S_NEXT_KEY;
            end else if (idx_q == LAST_IDX) begin
               state_d = S_FOUND;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = S_RD_ADDR;
            end
         end
         S_NEXT_KEY: begin
            if (key_q == KEY_END) begin
               state_d = S_FAIL;
            end else begin
               key_d   = key_q + KEY_W'(1);
               first_d = 1'b0;
               state_d = S_START;
            end
         end
         S_FOUND, S_FAIL: begin
            found_d = (state_q == S_FOUND);
            fail_d  = (state_q == S_FAIL);
            busy_d  = 1'b0;
            // busy_q still high on the first terminal cycle, so go is ignored there
            if (bus.go_i && !busy_q) begin
               state_d = S_START;
               key_d   = KEY_START;
               first_d = 1'b1;
               busy_d  = 1'b1;
               found_d = 1'b0;
               fail_d  = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.key_o        = key_q;
   assign bus.address_d_o  = idx_q;
   assign bus.busy_o       = busy_q;
   assign bus.found_o      = found_q;
   assign bus.fail_o       = fail_q;
   assign bus.core_start_o = core_start_q;
   assign bus.start_loop_o = start_loop_q;

endmodule

// File: tb/tb_key_search_ctrl.sv
// Bench for key_search_ctrl: two instances (full key range and a 5..7 range),
// a timeline model of expected outputs per cycle, a D-memory model with
// two-cycle read latency and a core model returning pass_done after a fixed delay.
module tb_key_search_ctrl;
   localparam int NC       = 640;
   localparam int END_CYC  = 600;
   localparam int M        = 32;
   localparam int CORE_DLY = 4;

   logic clk;
   logic rst_n0, rst_n1;
   int   cyc = 0;
   int   n_assert = 0;
   int   n_fail = 0;
   int   start_cnt0 = 0, loop_cnt0 = 0, loop_cnt1 = 0;

   key_search_ctrl_if bus0 ();
   key_search_ctrl_if bus1 ();

   key_search_ctrl #(.MSG_LEN(32), .KEY_START(24'h000000), .KEY_END(24'h3FFFFF)) dut0 (
      .clk(clk), .rst_n(rst_n0), .bus(bus0));
   key_search_ctrl #(.MSG_LEN(32), .KEY_START(24'h000005), .KEY_END(24'h000007)) dut1 (
      .clk(clk), .rst_n(rst_n1), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // expected timeline and stimulus schedule
   bit          exp_busy  [2][NC];
   bit          exp_found [2][NC];
   bit          exp_fail  [2][NC];
   bit          exp_start [2][NC];
   bit          exp_loop  [2][NC];
   logic [23:0] exp_key   [2][NC];
   logic [7:0]  exp_addr  [2][NC];
   bit          addr_chk  [2][NC];
   bit          drv_go    [2][NC];
   bit          drv_pass  [2][NC];
   bit          drv_rst   [2][NC];
   int          phase     [2][NC];
   int          phase_now [2];

   string msg = "attack at dawn and hold the fort";

   // Decrypted byte j for a key, per scenario
   function automatic logic [7:0] msg_byte(input int i, input int ph, input logic [23:0] key, input int j);
      logic [7:0] b;
      if (j >= M) return 8'h20;
      b = msg[j];
      if (i == 1) begin
         if (j == 0) b = (key == 24'd5) ? 8'h00 : (key == 24'd6) ? 8'hFF : 8'h7B;
         return b;
      end
      case (ph)
         2: if (key == 24'd0 && j == 2) b = 8'h41;
         3: begin
            if (key == 24'd0 && j == 0)  b = 8'h60;
            if (key == 24'd1 && j == 1)  b = 8'h7B;
            if (key == 24'd2 && j == 0)  b = 8'h1F;
            if (key == 24'd3 && j == 5)  b = 8'h21;
            if (key == 24'd4 && j == 0)  b = 8'h61;
            if (key == 24'd4 && j == 4)  b = 8'h20;
            if (key == 24'd4 && j == 31) b = 8'h7A;
         end
         4: if (key == 24'd0 && j == 3) b = 8'h80;
         default: ;
      endcase
      return b;
   endfunction

   function automatic bit printable(input logic [7:0] b);
      return (b >= 8'h61 && b <= 8'h7A) || b == 8'h20;
   endfunction

   task automatic fill(input int i, input int from, input bit b, input bit f, input bit x, input logic [23:0] k);
      for (int c = from; c < NC; c++) begin
         exp_busy[i][c] = b; exp_found[i][c] = f; exp_fail[i][c] = x; exp_key[i][c] = k;
      end
   endtask

   // Reset held low for cycles a0..a1-1, released after edge a1
   task automatic plan_reset(input int i, input int a0, input int a1, input logic [23:0] ks);
      fill(i, a0, 1'b0, 1'b0, 1'b0, ks);
      for (int c = a0; c < NC; c++) begin
         exp_start[i][c] = 1'b0; exp_loop[i][c] = 1'b0; addr_chk[i][c] = 1'b0; drv_pass[i][c] = 1'b0;
      end
      for (int c = a0; c < a1; c++) drv_rst[i][c] = 1'b0;
      for (int c = a0; c <= a1; c++) begin addr_chk[i][c] = 1'b1; exp_addr[i][c] = 8'h00; end
   endtask

   // go sampled at edge g; walk keys until a fully printable message or the end key
   task automatic plan_search(input int i, input int g, input int ph, input logic [23:0] ks, input logic [23:0] ke);
      int cur, s, p, k, last;
      logic [23:0] key;
      bit first, done;
      drv_go[i][g-1] = 1'b1;
      for (int c = g - 1; c < NC; c++) phase[i][c] = ph;
      key = ks; cur = g; first = 1'b1; done = 1'b0;
      fill(i, g, 1'b1, 1'b0, 1'b0, key);
      while (!done) begin
         s = cur + 1;
         if (first) exp_start[i][s] = 1'b1; else exp_loop[i][s] = 1'b1;
         p = s + CORE_DLY;
         drv_pass[i][p-1] = 1'b1;
         k = -1;
         for (int j = 0; j < M; j++) if (k < 0 && !printable(msg_byte(i, ph, key, j))) k = j;
         last = (k < 0) ? M - 1 : k;
         for (int j = 0; j <= last; j++)
            for (int t = 0; t < 3; t++) begin
               addr_chk[i][p+3*j+t] = 1'b1; exp_addr[i][p+3*j+t] = 8'(j);
            end
         if (k < 0) begin
            fill(i, p + 3*M + 1, 1'b0, 1'b1, 1'b0, key); done = 1'b1;
         end else if (key == ke) begin
            fill(i, p + 3*k + 5, 1'b0, 1'b0, 1'b1, key); done = 1'b1;
         end else begin
            key = key + 24'd1; cur = p + 3*k + 4; first = 1'b0;
            fill(i, cur, 1'b1, 1'b0, 1'b0, key);
         end
      end
   endtask

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] want);
      n_assert++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s inst%0d cyc%0d got %0h want %0h", nm, i, cyc, act, want);
      end
   endtask

   // D memory model, two-cycle read latency
   logic [7:0] m1_0, m1_1, q0, q1;
   always @(posedge clk) begin
      m1_0 <= msg_byte(0, phase_now[0], bus0.key_o, int'(bus0.address_d_o));
      m1_1 <= msg_byte(1, phase_now[1], bus1.key_o, int'(bus1.address_d_o));
      q0   <= m1_0;
      q1   <= m1_1;
   end
   assign bus0.q_d_i = q0;
   assign bus1.q_d_i = q1;

   // Stimulus driver: values applied 1 time unit after each edge
   always @(posedge clk) begin
      cyc = cyc + 1;
      #1;
      if (cyc < NC) begin
         rst_n0 = drv_rst[0][cyc]; rst_n1 = drv_rst[1][cyc];
         bus0.go_i = drv_go[0][cyc]; bus1.go_i = drv_go[1][cyc];
         bus0.pass_done_i = drv_pass[0][cyc]; bus1.pass_done_i = drv_pass[1][cyc];
         phase_now[0] = phase[0][cyc]; phase_now[1] = phase[1][cyc];
      end
   end

   // Pulse counters
   always @(negedge clk) begin
      if (bus0.core_start_o) start_cnt0++;
      if (bus0.start_loop_o) loop_cnt0++;
      if (bus1.start_loop_o) loop_cnt1++;
   end

   logic        a_busy [2], a_found [2], a_fail [2], a_start [2], a_loop [2];
   logic [23:0] a_key  [2];
   logic [7:0]  a_addr [2];
   assign a_busy[0] = bus0.busy_o;        assign a_busy[1] = bus1.busy_o;
   assign a_found[0] = bus0.found_o;      assign a_found[1] = bus1.found_o;
   assign a_fail[0] = bus0.fail_o;        assign a_fail[1] = bus1.fail_o;
   assign a_start[0] = bus0.core_start_o; assign a_start[1] = bus1.core_start_o;
   assign a_loop[0] = bus0.start_loop_o;  assign a_loop[1] = bus1.start_loop_o;
   assign a_key[0] = bus0.key_o;          assign a_key[1] = bus1.key_o;
   assign a_addr[0] = bus0.address_d_o;   assign a_addr[1] = bus1.address_d_o;

   // Per-cycle comparison against the timeline model
   always @(negedge clk) begin
      if (cyc >= 1 && cyc < END_CYC) begin
         for (int i = 0; i < 2; i++) begin
            chk("busy",  i, 32'(a_busy[i]),  32'(exp_busy[i][cyc]));
            chk("found", i, 32'(a_found[i]), 32'(exp_found[i][cyc]));
            chk("fail",  i, 32'(a_fail[i]),  32'(exp_fail[i][cyc]));
            chk("start", i, 32'(a_start[i]), 32'(exp_start[i][cyc]));
            chk("loop",  i, 32'(a_loop[i]),  32'(exp_loop[i][cyc]));
            chk("key",   i, 32'(a_key[i]),   32'(exp_key[i][cyc]));
            if (addr_chk[i][cyc]) chk("addr", i, 32'(a_addr[i]), 32'(exp_addr[i][cyc]));
         end
      end
   end

   task automatic at_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   initial begin
      rst_n0 = 1'b0; rst_n1 = 1'b0;
      bus0.go_i = 1'b0; bus0.pass_done_i = 1'b0;
      bus1.go_i = 1'b0; bus1.pass_done_i = 1'b0;
      phase_now[0] = 1; phase_now[1] = 1;
      for (int i = 0; i < 2; i++)
         for (int c = 0; c < NC; c++) begin
            exp_busy[i][c] = 0; exp_found[i][c] = 0; exp_fail[i][c] = 0;
            exp_start[i][c] = 0; exp_loop[i][c] = 0; addr_chk[i][c] = 0;
            exp_key[i][c] = (i == 0) ? 24'd0 : 24'd5; exp_addr[i][c] = 8'h00;
            drv_go[i][c] = 0; drv_pass[i][c] = 0; drv_rst[i][c] = 1; phase[i][c] = 1;
         end

      plan_reset(0, 0, 10, 24'd0);
      plan_reset(1, 0, 10, 24'd5);
      drv_go[0][2] = 1'b1; drv_go[0][5] = 1'b1;
      plan_search(0, 20, 1, 24'd0, 24'h3FFFFF);
      plan_search(0, 130, 2, 24'd0, 24'h3FFFFF);
      plan_search(0, 260, 3, 24'd0, 24'h3FFFFF);
      plan_search(0, 430, 4, 24'd0, 24'h3FFFFF);
      drv_go[0][436] = 1'b1;
      drv_pass[0][438] = 1'b1;
      plan_reset(0, 451, 455, 24'd0);
      plan_search(0, 470, 1, 24'd0, 24'h3FFFFF);
      plan_search(1, 20, 1, 24'd5, 24'd7);

      // Hand-computed anchors
      at_cyc(5);
      chk("lit_rst_busy", 0, 32'(bus0.busy_o), 32'd0);
      chk("lit_rst_key0", 0, 32'(bus0.key_o), 32'd0);
      chk("lit_rst_key1", 1, 32'(bus1.key_o), 32'd5);
      at_cyc(21);
      chk("lit_core_start", 0, 32'(bus0.core_start_o), 32'd1);
      chk("lit_core_start", 1, 32'(bus1.core_start_o), 32'd1);
      at_cyc(30);
      chk("lit_loop_key6", 1, {31'd0, bus1.start_loop_o}, 32'd1);
      chk("lit_key6", 1, 32'(bus1.key_o), 32'd6);
      at_cyc(48);
      chk("lit_fail", 1, 32'(bus1.fail_o), 32'd1);
      chk("lit_fail_key", 1, 32'(bus1.key_o), 32'd7);
      chk("lit_fail_busy", 1, 32'(bus1.busy_o), 32'd0);
      at_cyc(121);
      chk("lit_found_96", 0, 32'(bus0.found_o), 32'd0);
      at_cyc(122);
      chk("lit_found_97", 0, 32'(bus0.found_o), 32'd1);
      chk("lit_found_key", 0, 32'(bus0.key_o), 32'd0);
      at_cyc(146);
      chk("lit_abort_loop", 0, 32'(bus0.start_loop_o), 32'd1);
      chk("lit_abort_key", 0, 32'(bus0.key_o), 32'd1);
      at_cyc(247);
      chk("lit_found_key1", 0, {8'd0, bus0.key_o}, 32'd1);
      chk("lit_found_k1", 0, 32'(bus0.found_o), 32'd1);
      at_cyc(416);
      chk("lit_bound_found", 0, 32'(bus0.found_o), 32'd1);
      chk("lit_bound_key", 0, 32'(bus0.key_o), 32'd4);
      at_cyc(460);
      chk("lit_midrst_busy", 0, 32'(bus0.busy_o), 32'd0);
      chk("lit_midrst_key", 0, 32'(bus0.key_o), 32'd0);
      at_cyc(471);
      chk("lit_restart", 0, 32'(bus0.core_start_o), 32'd1);
      at_cyc(572);
      chk("lit_restart_found", 0, 32'(bus0.found_o), 32'd1);
      at_cyc(END_CYC);
      chk("lit_start_cnt", 0, 32'(start_cnt0), 32'd5);
      chk("lit_loop_cnt", 0, 32'(loop_cnt0), 32'd6);
      chk("lit_loop_cnt", 1, 32'(loop_cnt1), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/key_search_ctrl.md
# key_search_ctrl

Brute-force key search controller on the consumer side of the RC4 decryption core. It drives the current 24-bit key and the start / next-loop pulses into the core, then waits for pass completion. After each pass it reads the decrypted message back out of D memory and checks every byte for printable lowercase text. It either declares the key found, advances to the next key, or declares the key space exhausted.

## Interface
- MSG_LEN, 32: number of decrypted bytes checked per pass (1..256); D addresses 0..MSG_LEN-1.
- KEY_START, 24'h000000: first key tried.
- KEY_END, 24'h3FFFFF: last key tried (inclusive); KEY_END >= KEY_START.
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- go_i  in  1  one-cycle request to begin a search at KEY_START.
- key_o  out  24  key under test; stable from the start pulse to the end of the check.
- core_start_o  out  1  one-cycle pulse, first key of a search (to core start).
- start_loop_o  out  1  one-cycle pulse, every subsequent key (to core start_loop_i).
- pass_done_i  in  1  one-cycle pulse from core: D memory fully written for key_o.
- address_d_o  out  8  D memory read address.
- q_d_i  in  8  D memory read data.
- busy_o  out  1  high from go accepted until FOUND or FAIL.
- found_o  out  1  sticky: key_o decrypts to valid text.
- fail_o  out  1  sticky: KEY_END tried without success.

## Operation
- States: IDLE, START, WAIT_PASS, RD_ADDR, RD_WAIT, CHECK, NEXT_KEY, FOUND, FAIL.
- IDLE: on go_i, load key_o = KEY_START, clear found_o and fail_o, go to START.
- START: assert core_start_o for one cycle (first key) or start_loop_o for one cycle (later keys), then go to WAIT_PASS.
- WAIT_PASS: on pass_done_i, clear the byte index to 0 and go to RD_ADDR.
- RD_ADDR: drive address_d_o = index, then go to RD_WAIT.
- RD_WAIT: hold address_d_o; this is the read-latency wait state.
- CHECK: sample q_d_i and test the byte.
  - A byte is valid iff 8'h61 <= q <= 8'h7A or q == 8'h20.
  - Invalid byte: abort immediately (early exit) and go to NEXT_KEY.
  - Valid byte with index == MSG_LEN-1: go to FOUND.
  - Otherwise: index+1, go to RD_ADDR.
- NEXT_KEY: if key_o == KEY_END, go to FAIL. Otherwise key_o = key_o+1 (24-bit, no wrap possible given the KEY_END bound) and go to START.
- FOUND: found_o=1, busy_o=0, key_o held.
- FAIL: fail_o=1, busy_o=0, key_o holds KEY_END.
- go_i in FOUND or FAIL restarts the search exactly as from IDLE. go_i is ignored while busy_o=1.
- pass_done_i is ignored outside WAIT_PASS.
- The index counter is 8 bits wide; address_d_o = index, zero-extended when MSG_LEN < 256.

## Timing
- Reset values: state IDLE, key_o=KEY_START, address_d_o=0, all 1-bit outputs 0.
- Reset asserted mid-search returns to IDLE asynchronously. No start pulse is emitted on reset release.
- go_i sampled high at edge N: busy_o and key_o update at edge N; core_start_o is high for the cycle after edge N+1.
- D memory read latency is 2 cycles: address driven in RD_ADDR, q_d_i valid in CHECK.
- Each byte takes 3 cycles. For a fully valid pass, FOUND is reached 3*MSG_LEN+1 cycles after pass_done_i.
- Abort at index k: the start_loop_o pulse occurs 3*(k+1)+2 cycles after pass_done_i.
- core_start_o and start_loop_o are never high together, and each is never high for more than one cycle.
- found_o and fail_o are mutually exclusive and registered.

## Test plan
- Reset: hold rst_n=0, toggle go_i -> all outputs 0, key_o=KEY_START, no pulses.
- First key valid: go_i, model returns "attack at dawn..." (32 bytes of a-z/space) after pass_done_i -> core_start_o one pulse, addresses 0..31, found_o=1 at pass_done+97, key_o=0.
- Early abort: byte 2 = 8'h41 for key 0, all valid for key 1 -> addresses 0..2 only, then start_loop_o pulse with key_o=1, then found_o with key_o=1.
- Exhaustion: KEY_START=5, KEY_END=7, every pass invalid at byte 0 -> exactly 2 start_loop_o pulses, fail_o=1, key_o=7, busy_o=0.
- Boundary bytes: q of 8'h60, 8'h7B, 8'h1F, 8'h21 rejected; 8'h61, 8'h7A, 8'h20 accepted.
- Robustness: spurious pass_done_i during CHECK and go_i while busy -> ignored. Reset pulsed during WAIT_PASS -> IDLE; a later go_i restarts at KEY_START.
